// File: rtl/rr_mux2_arbiter.sv
// rtl/rr_mux2_arbiter.sv - two-channel arbiter feeding a registered 2:1 mux stage
// Optional macro RR_MUX2_FIXED_PRIO_EN: A always wins contention, no round-robin pointer.
module rr_mux2_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_y_data;
  logic             r_y_valid;
  logic             r_sel;

  logic             w_gnt_b;
  logic             w_any;
  logic             w_can_accept;
  logic             w_take;

`ifdef RR_MUX2_FIXED_PRIO_EN
  always_comb begin
    w_gnt_b = b_valid & ~a_valid;
  end
`else
  // r_last_b: 1 when B won the last accepted beat; reset to 1 so A wins first contention
  logic r_last_b;

  always_comb begin
    w_gnt_b = b_valid & (~a_valid | ~r_last_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (w_take) begin
      r_last_b <= w_gnt_b;
    end
  end
`endif

  assign w_any        = a_valid | b_valid;
  // Drain-and-refill: a FULL stage being emptied this cycle can take a new beat
  assign w_can_accept = ~rst & ((r_state == EMPTY) | y_ready);
  assign w_take       = w_can_accept & w_any;

  assign a_ready = w_can_accept & a_valid & ~w_gnt_b;
  assign b_ready = w_can_accept & w_gnt_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_y_valid <= 1'b0;
      r_y_data  <= '0;
      r_sel     <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_take) begin
            r_y_data  <= w_gnt_b ? b_data : a_data;
            r_sel     <= w_gnt_b;
            r_y_valid <= 1'b1;
            r_state   <= FULL;
          end
        end
        FULL: begin
          if (w_take) begin
            r_y_data  <= w_gnt_b ? b_data : a_data;
            r_sel     <= w_gnt_b;
          end else if (y_ready) begin
            r_y_valid <= 1'b0;
            r_state   <= EMPTY;
          end
        end
        default: begin
          r_y_valid <= 1'b0;
          r_state   <= EMPTY;
        end
      endcase
    end
  end

  assign y_data  = r_y_data;
  assign y_valid = r_y_valid;
  assign sel     = r_sel;

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// tb/tb_rr_mux2_arbiter.sv - scoreboard bench for rr_mux2_arbiter (WIDTH=8)
// Honours RR_MUX2_FIXED_PRIO_EN in its reference model.
module tb_rr_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data, y_data;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic       y_valid, y_ready, sel;

  int checks   = 0;
  int failures = 0;

  // Expected output beats: {sel, data}, capacity-1 stage so at most one pending
  logic [8:0] sb_q[$];
  bit         last_b  = 1'b1;
  bit         mon_en  = 1'b0;

  rr_mux2_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: negedge+1, inputs already stable for the coming edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check("y_valid_occupancy", {31'd0, y_valid}, {31'd0, sb_q.size() != 0});
        if (y_valid === 1'b1 && y_ready === 1'b1 && sb_q.size() != 0) begin
          logic [8:0] exp_beat;
          exp_beat = sb_q.pop_front();
          check("out_beat_sel_data", {23'd0, sel, y_data}, {23'd0, exp_beat});
        end
      end
    end
  end

  // Driver + reference model: negedge drive, negedge+2 check readies and predict
  task automatic cycle(input bit r, input bit av, input logic [7:0] ad,
                       input bit bv, input logic [7:0] bd, input bit yr);
    bit exp_a, exp_b, win_b;
    @(negedge clk);
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    #2;
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (!r && sb_q.size() == 0 && (av || bv)) begin
      if (av && bv) begin
`ifdef RR_MUX2_FIXED_PRIO_EN
        win_b = 1'b0;
`else
        win_b = !last_b;
`endif
      end else begin
        win_b = bv;
      end
      exp_a = !win_b;
      exp_b = win_b;
      sb_q.push_back({win_b, win_b ? bd : ad});
      last_b = win_b;
    end
    check("a_ready", {31'd0, a_ready}, {31'd0, exp_a});
    check("b_ready", {31'd0, b_ready}, {31'd0, exp_b});
    if (r) begin
      sb_q.delete();
      last_b = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; y_ready = 1'b0;

    // Reset with a beat waiting on A
    cycle(1, 1, 8'h55, 0, 8'h00, 0);
    cycle(1, 1, 8'h55, 0, 8'h00, 0);
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_y_data", {24'd0, y_data}, 32'h00);
    check("rst_sel", {31'd0, sel}, 32'd0);
    mon_en = 1'b1;
    cycle(0, 0, 8'h00, 0, 8'h00, 1);

    // Single channel B
    cycle(0, 0, 8'h00, 1, 8'hB1, 1);
    cycle(0, 0, 8'h00, 0, 8'h00, 1);
    check("single_b_data", {24'd0, y_data}, 32'hB1);
    check("single_b_sel", {31'd0, sel}, 32'd1);

    // Contention, 4 cycles (RR: 0,1,0,1; fixed: 0,0,0,0)
    repeat (4) cycle(0, 1, 8'hA0, 1, 8'hB0, 1);
    cycle(0, 1, 8'hA0, 0, 8'h00, 1);

    // Backpressure while holding A0
    repeat (3) begin
      cycle(0, 1, 8'hA0, 1, 8'hB0, 0);
      check("bp_y_data", {24'd0, y_data}, 32'hA0);
      check("bp_sel", {31'd0, sel}, 32'd0);
      check("bp_y_valid", {31'd0, y_valid}, 32'd1);
    end
    cycle(0, 1, 8'hA0, 1, 8'hB0, 1);

    // Drain without refill
    cycle(0, 0, 8'h00, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 0, 8'h00, 1);
`ifdef RR_MUX2_FIXED_PRIO_EN
    check("drain_y_data", {24'd0, y_data}, 32'hA0);
`else
    check("drain_y_data", {24'd0, y_data}, 32'hB0);
`endif

    // Reset mid-operation with B0 held
    cycle(0, 0, 8'h00, 1, 8'hB0, 1);
    cycle(1, 1, 8'hA0, 1, 8'hB0, 0);
    cycle(0, 1, 8'hA0, 1, 8'hB0, 1);
    check("midrst_sel", {31'd0, sel}, 32'd0);
    cycle(0, 0, 8'h00, 0, 8'h00, 1);
    check("midrst_grant_a", {23'd0, sel, y_data}, {23'd0, 1'b0, 8'hA0});

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    end

    repeat (3) cycle(0, 0, 8'h00, 0, 8'h00, 1);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
